// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU datapath definitions used by the register file, its scoreboard
// and the ALU/zero-detect stage downstream.
//   DATA_W    : register / operand width
//   REG_N     : number of architectural registers
//   REG_AW    : register address width
//   ZERO_REG  : hardwired-zero register address
//   reg_addr_t, word_t : common address and data word types
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Pending-write tracker for the register file. One bit per register records
// that an issued instruction will still write that register back. Bit 0 is
// constant zero.
// Ports:
//   clk         in   system clock, state updates on rising edge
//   rst         in   asynchronous active-high reset, clears every pending bit
//   issue_valid in   an instruction with a destination issues this cycle
//   issue_rd    in   destination register of the issued instruction
//   wb_en       in   write-back strobe
//   wb_addr     in   write-back register address
//   rr1, rr2    in   lookup addresses
//   busy1,busy2 out  registered pending bit of rr1 / rr2
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_N_P = REG_N
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_addr_t rr1,
  input  reg_addr_t rr2,
  output logic      busy1,
  output logic      busy2
);

  logic [REG_N_P-1:0] pendingVec;

  assign pendingVec[0] = 1'b0;

  // One flop per real register. Set is tested before clear so that a new
  // producer issued on the same edge as the old one retires keeps the bit high.
  // Repeated issues (WAW) just leave the bit set; the first write-back clears it.
  for (genvar i = 1; i < REG_N_P; i++) begin : g_pending
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pendingVec[i] <= 1'b0;
      end else if (issue_valid && (issue_rd == REG_AW'(i))) begin
        pendingVec[i] <= 1'b1;
      end else if (wb_en && (wb_addr == REG_AW'(i))) begin
        pendingVec[i] <= 1'b0;
      end
    end
  end

  assign busy1 = pendingVec[rr1];
  assign busy2 = pendingVec[rr2];

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Two-read / one-write register file with a pending-write scoreboard. Feeds
// the RD1/RD2 operands of the ALU stage and tells the issue logic which
// operands still await a write-back. Register 0 reads as zero and ignores
// writes; it is never marked busy.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle
// write-back (data and busy clear) to the read ports. Without it, reads
// reflect only registered state.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   RR1, RR2          read addresses
//   RD1, RD2          combinational read data
//   busy1, busy2      operand has an outstanding write
//   RegWrite, WR, WD  write-back strobe, address, data
//   issue_valid       instruction with a destination issues this cycle
//   issue_rd          its destination register
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_N_P  = REG_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   RR1,
  input  logic [REG_AW-1:0]   RR2,
  output logic [DATA_W_P-1:0] RD1,
  output logic [DATA_W_P-1:0] RD2,
  output logic                busy1,
  output logic                busy2,
  input  logic                RegWrite,
  input  logic [REG_AW-1:0]   WR,
  input  logic [DATA_W_P-1:0] WD,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd
);

  logic [DATA_W_P-1:0] regView [REG_N_P];
  logic                wbValid;
  logic                pendBusy1;
  logic                pendBusy2;

  assign wbValid = RegWrite && (WR != ZERO_REG);

  // Entry 0 of the read view is a constant, so no storage exists for r0.
  assign regView[0] = '0;

  // Storage for r1..r31. Reset clears asynchronously, which also blocks any
  // write presented while rst is high.
  for (genvar i = 1; i < REG_N_P; i++) begin : g_regs
    logic [DATA_W_P-1:0] regQ;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regQ <= '0;
      end else if (wbValid && (WR == REG_AW'(i))) begin
        regQ <= WD;
      end
    end

    assign regView[i] = regQ;
  end

  reg_scoreboard #(
    .REG_N_P (REG_N_P)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid && (issue_rd != ZERO_REG)),
    .issue_rd    (issue_rd),
    .wb_en       (wbValid),
    .wb_addr     (WR),
    .rr1         (RR1),
    .rr2         (RR2),
    .busy1       (pendBusy1),
    .busy2       (pendBusy2)
  );

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;
  logic reissue;

  // Forwarding is suppressed during reset so outputs read zero while rst is
  // high. If the written register is also re-issued this cycle, busy keeps
  // the registered value because a newer producer is now outstanding.
  always_comb begin
    fwd1    = wbValid && !rst && (WR == RR1);
    fwd2    = wbValid && !rst && (WR == RR2);
    reissue = issue_valid && (issue_rd == WR);
    RD1     = fwd1 ? WD : regView[RR1];
    RD2     = fwd2 ? WD : regView[RR2];
    busy1   = (fwd1 && !reissue) ? 1'b0 : pendBusy1;
    busy2   = (fwd2 && !reissue) ? 1'b0 : pendBusy2;
  end
`else
  always_comb begin
    RD1   = regView[RR1];
    RD2   = regView[RR2];
    busy1 = pendBusy1;
    busy2 = pendBusy2;
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Directed bench for reg_file_sb. Each vector drives inputs shortly after a
// rising edge and queues the outputs expected during that cycle; a monitor
// samples on the falling edge and compares against the queue head.
// Honours REGFILE_BYPASS_EN for the cases whose result depends on it.
module tb_reg_file_sb;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  RR1 = '0;
  logic [4:0]  RR2 = '0;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        busy1;
  logic        busy2;
  logic        RegWrite = 1'b0;
  logic [4:0]  WR = '0;
  logic [31:0] WD = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .RR1         (RR1),
    .RR2         (RR2),
    .RD1         (RD1),
    .RD2         (RD2),
    .busy1       (busy1),
    .busy2       (busy2),
    .RegWrite    (RegWrite),
    .WR          (WR),
    .WD          (WD),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic applyStimulus(input string name, input logic r,
                               input logic [4:0] rr1, input logic [4:0] rr2,
                               input logic we, input logic [4:0] wr,
                               input logic [31:0] wd, input logic iv,
                               input logic [4:0] ird,
                               input logic [31:0] eRd1, input logic [31:0] eRd2,
                               input logic eB1, input logic eB2);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    RR1         = rr1;
    RR2         = rr2;
    RegWrite    = we;
    WR          = wr;
    WD          = wd;
    issue_valid = iv;
    issue_rd    = ird;
    e.name = name;
    e.rd1  = eRd1;
    e.rd2  = eRd2;
    e.b1   = eB1;
    e.b2   = eB2;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if (RD1 !== e.rd1 || RD2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
      testsFailed++;
      $display("[TB] FAIL %s: got RD1=%h RD2=%h busy1=%b busy2=%b, expected RD1=%h RD2=%h busy1=%b busy2=%b",
               e.name, RD1, RD2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
    end
  endtask

  // Monitor: the design always presents outputs, so every queued cycle is
  // sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    // name rst rr1 rr2 we wr wd iv ird | RD1 RD2 b1 b2
    applyStimulus("reset",     1, 5, 7, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus("wr5_iss5",  0, 5, 0, 1, 5, 32'hDEADBEEF, 1, 5,
                  BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 0);
    applyStimulus("r5_state",  0, 5, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 1, 0);
    applyStimulus("rst_mid",   1, 5, 6, 1, 5, 32'h11111111, 1, 6, 32'h0, 32'h0, 0, 0);
    applyStimulus("after_rst", 0, 5, 6, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus("w7_same",   0, 7, 7, 1, 7, 32'h12345678, 0, 0,
                  BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 0, 0);
    applyStimulus("r7",        0, 7, 7, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0);
    applyStimulus("zero_w",    0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus("zero_r",    0, 0, 7, 0, 0, 0, 0, 0, 32'h0, 32'h12345678, 0, 0);
    applyStimulus("iss3",      0, 0, 3, 0, 0, 0, 1, 3, 32'h0, 32'h0, 0, 0);
    applyStimulus("busy3_a",   0, 0, 3, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
    applyStimulus("busy3_b",   0, 0, 3, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
    applyStimulus("wb3",       0, 0, 3, 1, 3, 32'h0BADF00D, 0, 0,
                  32'h0, BYP ? 32'h0BADF00D : 32'h0, 0, !BYP);
    applyStimulus("done3",     0, 0, 3, 0, 0, 0, 0, 0, 32'h0, 32'h0BADF00D, 0, 0);
    applyStimulus("iss9",      0, 9, 0, 0, 0, 0, 1, 9, 32'h0, 32'h0, 0, 0);
    applyStimulus("coll9",     0, 9, 0, 1, 9, 32'h99990001, 1, 9,
                  BYP ? 32'h99990001 : 32'h0, 32'h0, 1, 0);
    applyStimulus("post9",     0, 9, 0, 0, 0, 0, 0, 0, 32'h99990001, 32'h0, 1, 0);
    applyStimulus("iss12_a",   0, 12, 12, 0, 0, 0, 1, 12, 32'h0, 32'h0, 0, 0);
    applyStimulus("iss12_b",   0, 12, 12, 0, 0, 0, 1, 12, 32'h0, 32'h0, 1, 1);
    applyStimulus("wb12",      0, 12, 12, 1, 12, 32'hA5A5A5A5, 0, 0,
                  BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, !BYP, !BYP);
    applyStimulus("done12",    0, 12, 12, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
    applyStimulus("wb_nonpend",0, 20, 0, 1, 20, 32'h20202020, 0, 0,
                  BYP ? 32'h20202020 : 32'h0, 32'h0, 0, 0);
    applyStimulus("r20",       0, 20, 7, 0, 0, 0, 0, 0, 32'h20202020, 32'h12345678, 0, 0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expQ.size() > 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
